hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the fetch → decode → execute front end.
- Generates enable and flush controls for the PC, the IF/ID register set and the ID/EX register set.
- Keeps a register scoreboard for long-latency writes (loads, multiply/divide) and stalls decode on RAW/WAW hazards against them.
- Runs a small FSM that drains the pipe after a branch redirect and freezes it while the multi-cycle MDU is busy.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_scoreboard.sv | 52 +++++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the fetch/decode/execute sequencing controller:
// FSM states, stall cause codes and register index width.
package hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_HAZARD   = 2'd1;
  localparam logic [1:0] CAUSE_MDU      = 2'd2;
  localparam logic [1:0] CAUSE_REDIRECT = 2'd3;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for long-latency destinations and the RAW/WAW
// hazard lookup for the instruction currently in decode.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] rs1_ind,
  input  logic [REG_IDX_W-1:0] rs2_ind,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic [REG_IDX_W-1:0] rd_ind,
  input  logic                 rd_we,
  input  logic                 set_en,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_ind,
  output logic                 hazard,
  output logic [NREG-1:0]      sb
);

  logic [NREG-1:0] sb_next;

  // Clear first, then set: a same-cycle set belongs to a younger writer and wins.
  always_comb begin
    sb_next = sb;
    if (clr_en) begin
      sb_next[clr_ind] = 1'b0;
    end
    if (set_en && (rd_ind != '0)) begin
      sb_next[rd_ind] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  always_comb begin
    hazard = id_valid & ((rs1_used & sb[rs1_ind]) |
                         (rs2_used & sb[rs2_ind]) |
                         (rd_we    & sb[rd_ind]));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF-ID / ID-EX enables and flushes,
// scoreboard-based decode stalls, redirect drain and MDU freeze.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1_ind,
  input  logic [REG_IDX_W-1:0] id_rs2_ind,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] id_rd_ind,
  input  logic                 id_rd_we,
  input  logic                 id_long,
  input  logic                 id_is_mdu,
  input  logic                 mdu_done,
  input  logic                 redirect,
  input  logic                 wb_take,
  input  logic [REG_IDX_W-1:0] wb_rd_ind,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_en,
  output logic                 id_ex_flush,
  output logic                 issue,
  output logic [1:0]           stall_cause,
  output logic [1:0]           dbg_state,
  output logic [NREG-1:0]      dbg_sb
);

  // Counter holds the drain cycles still owed after the redirect cycle.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             hazard;
  logic [NREG-1:0]  sb;

  hazard_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .id_valid (id_valid),
    .rs1_ind  (id_rs1_ind),
    .rs2_ind  (id_rs2_ind),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd_ind   (id_rd_ind),
    .rd_we    (id_rd_we),
    .set_en   (issue & id_rd_we & id_long),
    .clr_en   (wb_take),
    .clr_ind  (wb_rd_ind),
    .hazard   (hazard),
    .sb       (sb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    issue       = 1'b0;
    stall_cause = CAUSE_NONE;
    state_next  = state;
    cnt_next    = cnt;

    if (redirect) begin
      // Also taken from MDU_WAIT, where it should never occur; draining is the safe exit.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      stall_cause = CAUSE_REDIRECT;
      if (FLUSH_CYCLES > 1) begin
        state_next = ST_DRAIN;
        cnt_next   = CNT_RELOAD;
      end else begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    end else begin
      case (state)
        ST_DRAIN: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          stall_cause = CAUSE_REDIRECT;
          if (cnt <= CNT_W'(1)) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        ST_MDU_WAIT: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          stall_cause = CAUSE_MDU;
          if (mdu_done) begin
            state_next = ST_RUN;
          end
        end
        default: begin
          if (hazard) begin
            // Hold PC and IF/ID, push a bubble into EX.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_cause = CAUSE_HAZARD;
          end else begin
            issue = id_valid;
            if (id_valid && id_is_mdu) begin
              state_next = ST_MDU_WAIT;
            end
          end
        end
      endcase
    end

    if (!rst_n) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      issue       = 1'b0;
      stall_cause = CAUSE_NONE;
    end
  end

  assign dbg_state = state;
  assign dbg_sb    = sb;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic checked
// against a pending-register / drain-count / MDU-busy reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int NREG         = 32;
  localparam int FLUSH_CYCLES = 2;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [4:0]      id_rs1_ind;
  logic [4:0]      id_rs2_ind;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [4:0]      id_rd_ind;
  logic            id_rd_we;
  logic            id_long;
  logic            id_is_mdu;
  logic            mdu_done;
  logic            redirect;
  logic            wb_take;
  logic [4:0]      wb_rd_ind;
  logic            pc_en;
  logic            if_id_en;
  logic            if_id_flush;
  logic            id_ex_en;
  logic            id_ex_flush;
  logic            issue;
  logic [1:0]      stall_cause;
  logic [1:0]      dbg_state;
  logic [NREG-1:0] dbg_sb;

  hazard_ctrl #(
    .NREG         (NREG),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1_ind  (id_rs1_ind),
    .id_rs2_ind  (id_rs2_ind),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd_ind   (id_rd_ind),
    .id_rd_we    (id_rd_we),
    .id_long     (id_long),
    .id_is_mdu   (id_is_mdu),
    .mdu_done    (mdu_done),
    .redirect    (redirect),
    .wb_take     (wb_take),
    .wb_rd_ind   (wb_rd_ind),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_en    (id_ex_en),
    .id_ex_flush (id_ex_flush),
    .issue       (issue),
    .stall_cause (stall_cause),
    .dbg_state   (dbg_state),
    .dbg_sb      (dbg_sb)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which registers await a long write, flush cycles
  // still owed, and whether the MDU holds the pipe.
  logic [NREG-1:0] pend;
  int              drain_left;
  bit              mdu_busy;
  logic [7:0]      exp_o;
  logic [7:0]      obs;
  int              checks;
  int              errors;

  // Output vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, issue, cause[1:0]
  function automatic logic [7:0] predict();
    logic hz;
    hz = id_valid && ((id_rs1_used && pend[id_rs1_ind]) ||
                      (id_rs2_used && pend[id_rs2_ind]) ||
                      (id_rd_we    && pend[id_rd_ind]));
    if (!rst_n)                        return 8'b0010_1000;
    if (redirect || drain_left > 0)    return 8'b1111_1011;
    if (mdu_busy)                      return 8'b0000_0010;
    if (hz)                            return 8'b0001_1001;
    return {5'b11010, id_valid, 2'b00};
  endfunction

  task automatic settle();
    #1;
    obs   = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, issue, stall_cause};
    exp_o = predict();
  endtask

  // Update the model with this cycle's inputs, then cross the clock edge.
  task automatic advance();
    logic [7:0] e;
    e = predict();
    if (!rst_n) begin
      pend       = '0;
      drain_left = 0;
      mdu_busy   = 1'b0;
    end else begin
      if (wb_take) pend[wb_rd_ind] = 1'b0;
      if (e[2] && id_rd_we && id_long && id_rd_ind != 5'd0) pend[id_rd_ind] = 1'b1;
      if (redirect) begin
        drain_left = FLUSH_CYCLES - 1;
        mdu_busy   = 1'b0;
      end else if (drain_left > 0) begin
        drain_left--;
      end else if (mdu_busy) begin
        if (mdu_done) mdu_busy = 1'b0;
      end else if (e[2] && id_is_mdu) begin
        mdu_busy = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic clear_inputs();
    id_valid    = 1'b0;
    id_rs1_ind  = '0;
    id_rs2_ind  = '0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_rd_ind   = '0;
    id_rd_we    = 1'b0;
    id_long     = 1'b0;
    id_is_mdu   = 1'b0;
    mdu_done    = 1'b0;
    redirect    = 1'b0;
    wb_take     = 1'b0;
    wb_rd_ind   = '0;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                             input logic u2, input logic [4:0] rd, input logic we,
                             input logic lng, input logic mdu);
    id_valid    = 1'b1;
    id_rs1_ind  = rs1;
    id_rs1_used = u1;
    id_rs2_ind  = rs2;
    id_rs2_used = u2;
    id_rd_ind   = rd;
    id_rd_we    = we;
    id_long     = lng;
    id_is_mdu   = mdu;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    id_valid = 1'b1;
    @(negedge clk);
    settle();
    checks++;
    if (obs !== 8'b0010_1000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 8'b0010_1000);
    end
    checks++;
    if (dbg_sb !== '0 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL reset_state: sb %h state %0d expected sb 0 state RUN", dbg_sb, dbg_state);
    end
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_no_hazard();
    clear_inputs();
    drive_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (obs !== exp_o || obs[2] !== 1'b1) begin
        errors++;
        $display("FAIL no_hazard[%0d]: got %b expected %b", i, obs, exp_o);
      end
      advance();
    end
    checks++;
    if (dbg_sb !== '0) begin
      errors++;
      $display("FAIL no_hazard_sb: got %h expected 0", dbg_sb);
    end
  endtask

  task automatic test_load_use();
    int stalls;
    stalls = 0;
    clear_inputs();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    settle();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL load_issue: got %b expected %b", obs, exp_o);
    end
    advance();
    drive_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wb_take   = (i == 3);
      wb_rd_ind = 5'd5;
      settle();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL load_use_stall[%0d]: got %b expected %b", i, obs, exp_o);
      end
      if (obs[3] && obs[1:0] == 2'd1 && !obs[7]) stalls++;
      advance();
    end
    wb_take = 1'b0;
    settle();
    checks++;
    if (obs !== exp_o || stalls != 4 || issue !== 1'b1) begin
      errors++;
      $display("FAIL load_use_resume: got %b stalls %0d expected %b stalls 4", obs, stalls, exp_o);
    end
    advance();
  endtask

  task automatic test_redirect();
    int flushes;
    bit pc_ok;
    flushes = 0;
    pc_ok   = 1'b1;
    clear_inputs();
    drive_instr(5'd1, 1'b1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      redirect = (i == 0);
      if (i == 1) id_valid = 1'b0;
      settle();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL redirect[%0d]: got %b expected %b", i, obs, exp_o);
      end
      if (if_id_flush && id_ex_flush && stall_cause == 2'd3) begin
        flushes++;
        if (!pc_en) pc_ok = 1'b0;
      end
      advance();
    end
    checks++;
    if (flushes != FLUSH_CYCLES || !pc_ok || dbg_sb !== '0) begin
      errors++;
      $display("FAIL redirect_drain: flushes %0d pc_ok %0d sb %h expected %0d 1 0",
               flushes, pc_ok, dbg_sb, FLUSH_CYCLES);
    end
  endtask

  task automatic test_mdu();
    int frozen;
    frozen = 0;
    clear_inputs();
    drive_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b1, 1'b1);
    settle();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL mdu_issue: got %b expected %b", obs, exp_o);
    end
    advance();
    drive_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      mdu_done = (i == 4);
      settle();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL mdu_wait[%0d]: got %b expected %b", i, obs, exp_o);
      end
      if (!pc_en && !if_id_en && !id_ex_en) frozen++;
      advance();
    end
    checks++;
    if (frozen != 5) begin
      errors++;
      $display("FAIL mdu_freeze_len: got %0d expected 5", frozen);
    end
    clear_inputs();
    wb_take   = 1'b1;
    wb_rd_ind = 5'd10;
    advance();
    wb_take = 1'b0;
  endtask

  task automatic test_same_cycle_and_x0();
    clear_inputs();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    wb_take   = 1'b1;
    wb_rd_ind = 5'd7;
    settle();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL set_clr_issue: got %b expected %b", obs, exp_o);
    end
    advance();
    checks++;
    if (dbg_sb[7] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: sb[7] %b expected 1", dbg_sb[7]);
    end
    wb_take = 1'b0;
    drive_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (obs !== exp_o || issue !== 1'b1 || dbg_sb[0] !== 1'b0) begin
        errors++;
        $display("FAIL x0_no_stall[%0d]: got %b sb0 %b expected %b", i, obs, dbg_sb[0], exp_o);
      end
      advance();
    end
    clear_inputs();
    wb_take   = 1'b1;
    wb_rd_ind = 5'd7;
    advance();
    wb_take = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    clear_inputs();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    advance();
    clear_inputs();
    redirect = 1'b1;
    advance();
    redirect = 1'b0;
    rst_n    = 1'b0;
    settle();
    checks++;
    if (obs !== 8'b0010_1000 || dbg_sb !== '0 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL reset_mid_drain: got %b sb %h state %0d expected %b sb 0 RUN",
               obs, dbg_sb, dbg_state, 8'b0010_1000);
    end
    advance();
    rst_n = 1'b1;
    id_valid = 1'b1;
    settle();
    checks++;
    if (obs !== exp_o || obs !== 8'b1101_0100) begin
      errors++;
      $display("FAIL after_reset_run: got %b expected %b", obs, exp_o);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      if ($urandom_range(0, 3) != 0) begin
        drive_instr(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      end
      mdu_done  = mdu_busy && ($urandom_range(0, 3) == 0);
      redirect  = ($urandom_range(0, 11) == 0);
      wb_take   = ($urandom_range(0, 2) == 0);
      wb_rd_ind = 5'($urandom_range(0, 7));
      settle();
      checks++;
      if (obs !== exp_o || dbg_sb !== pend) begin
        errors++;
        $display("FAIL random[%0d]: got %b sb %h expected %b sb %h", i, obs, dbg_sb, exp_o, pend);
      end
      advance();
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pend       = '0;
    drain_left = 0;
    mdu_busy   = 1'b0;
    rst_n      = 1'b0;
    clear_inputs();
    test_reset();
    test_no_hazard();
    test_load_use();
    test_redirect();
    test_mdu();
    test_same_cycle_and_x0();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
